// File: rtl/ooo_reorder_buffer_if.sv
// ooo_reorder_buffer_if: dispatch, CDB and commit signals of the reorder buffer.
// With OOO_ROB_FWD_EN defined it also carries the rename-stage operand lookup port.
interface ooo_reorder_buffer_if #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
);
    logic             flush;
    logic             alloc_valid;
    logic [4:0]       alloc_rd;
    logic             alloc_wen;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             commit_valid;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_data;
    logic             commit_wen;
    logic [TAG_W:0]   count;
`ifdef OOO_ROB_FWD_EN
    logic [4:0]       lu_rs;
    logic             lu_hit;
    logic             lu_ready;
    logic [31:0]      lu_data;
    logic [TAG_W-1:0] lu_tag;
`endif
    modport master (
        output flush, alloc_valid, alloc_rd, alloc_wen, cdb_valid, cdb_tag, cdb_data,
`ifdef OOO_ROB_FWD_EN
        output lu_rs,
        input  lu_hit, lu_ready, lu_data, lu_tag,
`endif
        input  alloc_ready, alloc_tag, commit_valid, commit_rd, commit_data, commit_wen, count
    );
    modport slave (
        input  flush, alloc_valid, alloc_rd, alloc_wen, cdb_valid, cdb_tag, cdb_data,
`ifdef OOO_ROB_FWD_EN
        input  lu_rs,
        output lu_hit, lu_ready, lu_data, lu_tag,
`endif
        output alloc_ready, alloc_tag, commit_valid, commit_rd, commit_data, commit_wen, count
    );
endinterface

// File: rtl/ooo_reorder_buffer.sv
// ooo_reorder_buffer: circular ROB, in-order alloc, out-of-order CDB completion, in-order commit.
// OOO_ROB_FWD_EN adds a youngest-match operand lookup for rename forwarding.
module ooo_reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input logic clock,
    input logic reset,
    ooo_reorder_buffer_if.slave rob
);
    logic [DEPTH-1:0] valid, done, wen;
    logic [4:0]       rd   [DEPTH];
    logic [31:0]      data [DEPTH];
    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   cnt;
    logic             do_alloc, do_cdb, do_commit;

    assign rob.alloc_ready = cnt != (TAG_W+1)'(DEPTH);
    assign rob.alloc_tag   = tail;
    assign rob.count       = cnt;
    assign do_alloc  = rob.alloc_valid & rob.alloc_ready;
    assign do_cdb    = rob.cdb_valid & valid[rob.cdb_tag] & ~done[rob.cdb_tag];
    assign do_commit = valid[head] & done[head] & ~rob.flush & ~reset;

    always_comb begin
        rob.commit_valid = do_commit;
        rob.commit_rd    = do_commit ? rd[head] : '0;
        rob.commit_data  = do_commit ? data[head] : '0;
        rob.commit_wen   = do_commit & wen[head] & (rd[head] != 5'd0);
    end

    // alloc only touches tail (invalid unless full) and CDB only valid entries, so updates never collide
    always_ff @(posedge clock) begin
        if (reset | rob.flush) begin
            valid <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
        end else begin
            if (do_alloc) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                wen[tail]   <= rob.alloc_wen;
                rd[tail]    <= rob.alloc_rd;
                tail        <= tail + TAG_W'(1);
            end
            if (do_cdb) begin
                done[rob.cdb_tag] <= 1'b1;
                data[rob.cdb_tag] <= rob.cdb_data;
            end
            if (do_commit) begin
                valid[head] <= 1'b0;
                head        <= head + TAG_W'(1);
            end
            cnt <= cnt + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
        end
    end

`ifdef OOO_ROB_FWD_EN
    logic [TAG_W-1:0] idx;
    // walk from oldest to youngest so the last match is the nearest to tail
    always_comb begin
        idx         = '0;
        rob.lu_hit  = 1'b0;
        rob.lu_tag  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + TAG_W'(i);
            if (valid[idx] && wen[idx] && rd[idx] == rob.lu_rs && rob.lu_rs != 5'd0) begin
                rob.lu_hit = 1'b1;
                rob.lu_tag = idx;
            end
        end
        rob.lu_ready = rob.lu_hit & done[rob.lu_tag];
        rob.lu_data  = rob.lu_ready ? data[rob.lu_tag] : '0;
    end
`endif
endmodule
